// File: rtl/spi_slave_responder.sv
// SPI mode-1 slave that streams fixed-length frames of WORD_BITS-bit words, MSB first.
// Define SPI_RESPONDER_LOOPBACK_EN to retransmit each received word as the following word.
`timescale 1ns/1ps
module spi_slave_responder #(
  parameter int WORD_BITS   = 24,
  parameter int FRAME_WORDS = 5
) (
  input  logic                 system_clock,
  input  logic                 reset_n,
  input  logic                 SPI_SCLK,
  input  logic                 SPI_CS,
  input  logic                 SPI_MOSI,
  output logic                 SPI_MISO,
  input  logic [WORD_BITS-1:0] tx_word,
  output logic                 tx_req,
  output logic [WORD_BITS-1:0] rx_word,
  output logic                 rx_valid,
  output logic [2:0]           word_index,
  output logic                 frame_done,
  output logic                 frame_error,
  output logic [1:0]           state
);

  localparam int CNT_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;
`ifdef SPI_RESPONDER_LOOPBACK_EN
  localparam bit LOOPBACK = 1'b1;
`else
  localparam bit LOOPBACK = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  logic sclk_s1_q, sclk_s2_q, sclk_dly_q;
  logic cs_s1_q, cs_s2_q, cs_dly_q;
  logic mosi_s1_q, mosi_s2_q;

  state_t               state_q, state_d;
  logic [WORD_BITS-1:0] tx_shift_q, tx_shift_d;
  logic [WORD_BITS-1:0] rx_shift_q, rx_shift_d;
  logic [WORD_BITS-1:0] rx_word_q, rx_word_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [2:0]           word_idx_q, word_idx_d;
  logic                 miso_q, miso_d;
  logic                 tx_req_q, tx_req_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_done_q, frame_done_d;
  logic                 frame_error_q, frame_error_d;
  logic [1:0]           warm_q, warm_d;
  logic                 armed_q, armed_d;

  logic                 sclk_rise, sclk_fall, cs_fall;
  logic [WORD_BITS-1:0] rx_next;
  logic [2:0]           idx_inc;

  assign sclk_rise = sclk_s2_q & ~sclk_dly_q;
  assign sclk_fall = ~sclk_s2_q & sclk_dly_q;
  assign cs_fall   = ~cs_s2_q & cs_dly_q;
  assign rx_next   = {rx_shift_q[WORD_BITS-2:0], mosi_s2_q};
  assign idx_inc   = word_idx_q + 3'd1;

  // A CS already low when reset lifts must not look like a fresh falling edge,
  // so frames are only accepted after CS has been seen high post-reset.
  always_comb begin
    warm_d  = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
    armed_d = armed_q | ((warm_q == 2'd2) & cs_s2_q);
  end

  always_comb begin
    state_d       = state_q;
    tx_shift_d    = tx_shift_q;
    rx_shift_d    = rx_shift_q;
    rx_word_d     = rx_word_q;
    bit_cnt_d     = bit_cnt_q;
    word_idx_d    = word_idx_q;
    miso_d        = miso_q;
    tx_req_d      = 1'b0;
    rx_valid_d    = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = frame_error_q;

    unique case (state_q)
      IDLE: begin
        miso_d = 1'b0;
        if (cs_fall && armed_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        miso_d        = 1'b0;
        tx_shift_d    = tx_word;
        tx_req_d      = 1'b1;
        rx_shift_d    = '0;
        bit_cnt_d     = '0;
        word_idx_d    = 3'd0;
        frame_error_d = 1'b0;
        state_d       = SHIFT;
      end
      SHIFT: begin
        // CS wins over any SCLK edge detected in the same cycle.
        if (cs_s2_q) begin
          state_d      = DONE;
          miso_d       = 1'b0;
          frame_done_d = 1'b1;
          if (bit_cnt_q != '0) begin
            frame_error_d = 1'b1;
          end
        end else if (sclk_rise) begin
          miso_d     = tx_shift_q[WORD_BITS-1];
          tx_shift_d = {tx_shift_q[WORD_BITS-2:0], 1'b0};
        end else if (sclk_fall) begin
          rx_shift_d = rx_next;
          if (word_idx_q >= 3'(FRAME_WORDS)) begin
            frame_error_d = 1'b1;
          end
          if (bit_cnt_q == CNT_W'(WORD_BITS - 1)) begin
            rx_word_d  = rx_next;
            rx_valid_d = 1'b1;
            bit_cnt_d  = '0;
            if (word_idx_q < 3'(FRAME_WORDS)) begin
              word_idx_d = idx_inc;
            end
            if ((word_idx_q < 3'(FRAME_WORDS)) && (idx_inc < 3'(FRAME_WORDS))) begin
              tx_shift_d = LOOPBACK ? rx_next : tx_word;
              tx_req_d   = !LOOPBACK;
            end else begin
              tx_shift_d = '0;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      DONE: begin
        miso_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge system_clock or negedge reset_n) begin
    if (!reset_n) begin
      sclk_s1_q     <= 1'b0;
      sclk_s2_q     <= 1'b0;
      sclk_dly_q    <= 1'b0;
      cs_s1_q       <= 1'b1;
      cs_s2_q       <= 1'b1;
      cs_dly_q      <= 1'b1;
      mosi_s1_q     <= 1'b0;
      mosi_s2_q     <= 1'b0;
      state_q       <= IDLE;
      tx_shift_q    <= '0;
      rx_shift_q    <= '0;
      rx_word_q     <= '0;
      bit_cnt_q     <= '0;
      word_idx_q    <= 3'd0;
      miso_q        <= 1'b0;
      tx_req_q      <= 1'b0;
      rx_valid_q    <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      warm_q        <= 2'd0;
      armed_q       <= 1'b0;
    end else begin
      sclk_s1_q     <= SPI_SCLK;
      sclk_s2_q     <= sclk_s1_q;
      sclk_dly_q    <= sclk_s2_q;
      cs_s1_q       <= SPI_CS;
      cs_s2_q       <= cs_s1_q;
      cs_dly_q      <= cs_s2_q;
      mosi_s1_q     <= SPI_MOSI;
      mosi_s2_q     <= mosi_s1_q;
      state_q       <= state_d;
      tx_shift_q    <= tx_shift_d;
      rx_shift_q    <= rx_shift_d;
      rx_word_q     <= rx_word_d;
      bit_cnt_q     <= bit_cnt_d;
      word_idx_q    <= word_idx_d;
      miso_q        <= miso_d;
      tx_req_q      <= tx_req_d;
      rx_valid_q    <= rx_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      warm_q        <= warm_d;
      armed_q       <= armed_d;
    end
  end

  assign SPI_MISO    = miso_q;
  assign tx_req      = tx_req_q;
  assign rx_word     = rx_word_q;
  assign rx_valid    = rx_valid_q;
  assign word_index  = word_idx_q;
  assign frame_done  = frame_done_q;
  assign frame_error = frame_error_q;
  assign state       = state_q;

endmodule

// File: tb/tb_spi_slave_responder.sv
// Self-checking bench for spi_slave_responder: an SPI mode-1 master model plus
// scoreboards for received words and the tx_word supply.
`timescale 1ns/1ps
module tb_spi_slave_responder;

  localparam int W  = 24;
  localparam int FW = 5;
`ifdef SPI_RESPONDER_LOOPBACK_EN
  localparam bit LB = 1'b1;
`else
  localparam bit LB = 1'b0;
`endif

  logic         system_clock = 1'b0;
  logic         reset_n      = 1'b1;
  logic         SPI_SCLK     = 1'b0;
  logic         SPI_CS       = 1'b1;
  logic         SPI_MOSI     = 1'b0;
  logic [W-1:0] tx_word      = '0;
  logic         SPI_MISO;
  logic         tx_req;
  logic [W-1:0] rx_word;
  logic         rx_valid;
  logic [2:0]   word_index;
  logic         frame_done;
  logic         frame_error;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;
  int rx_cnt = 0;
  int txreq_cnt = 0;
  int done_cnt = 0;

  logic [W-1:0] rx_exp_q[$];
  logic [W-1:0] tx_src_q[$];
  logic [W-1:0] txseq[FW];
  logic [W-1:0] mosi_w[8];
  logic [W-1:0] miso_got[8];

  spi_slave_responder #(.WORD_BITS(W), .FRAME_WORDS(FW)) dut (
    .system_clock(system_clock),
    .reset_n     (reset_n),
    .SPI_SCLK    (SPI_SCLK),
    .SPI_CS      (SPI_CS),
    .SPI_MOSI    (SPI_MOSI),
    .SPI_MISO    (SPI_MISO),
    .tx_word     (tx_word),
    .tx_req      (tx_req),
    .rx_word     (rx_word),
    .rx_valid    (rx_valid),
    .word_index  (word_index),
    .frame_done  (frame_done),
    .frame_error (frame_error),
    .state       (state)
  );

  always #10 system_clock = ~system_clock;

  // Supplies tx_word from the queue and scores every rx_valid pulse.
  always @(negedge system_clock) begin
    if (tx_req) begin
      txreq_cnt++;
      if (tx_src_q.size() > 0) void'(tx_src_q.pop_front());
    end
    tx_word = (tx_src_q.size() > 0) ? tx_src_q[0] : '0;
    if (frame_done) done_cnt++;
    if (rx_valid) begin
      rx_cnt++;
      checks++;
      if (rx_exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL rx_unexpected: got rx_word %h, required no rx_valid", rx_word);
      end else begin
        logic [W-1:0] exp;
        exp = rx_exp_q.pop_front();
        if (rx_word !== exp) begin
          errors++;
          $display("[TB] FAIL rx_word: got %h, required %h", rx_word, exp);
        end
      end
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(negedge system_clock);
  endtask

  task automatic spi_shift(input int nbits);
    for (int b = 0; b < nbits; b++) begin
      int wi;
      int bi;
      wi = b / W;
      bi = W - 1 - (b % W);
      SPI_SCLK = 1'b1;
      SPI_MOSI = mosi_w[wi][bi];
      wait_clks(6);
      SPI_SCLK = 1'b0;
      miso_got[wi][bi] = SPI_MISO;
      wait_clks(6);
    end
  endtask

  task automatic load_tx_seq();
    tx_src_q.delete();
    rx_exp_q.delete();
    for (int n = 0; n < FW; n++) tx_src_q.push_back(txseq[n]);
  endtask

  task automatic begin_frame();
    SPI_CS = 1'b0;
    wait_clks(10);
  endtask

  task automatic end_frame();
    SPI_CS   = 1'b1;
    SPI_MOSI = 1'b0;
    wait_clks(10);
  endtask

  function automatic logic [W-1:0] exp_miso(input int n);
    if (n >= FW) return '0;
    if (LB && n > 0) return mosi_w[n-1];
    return txseq[n];
  endfunction

  task automatic test_reset();
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #3;
    checks++;
    if ({state, SPI_MISO, tx_req, rx_valid, frame_done, frame_error, word_index, rx_word} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_values: got state=%0d miso=%b txreq=%b rxv=%b done=%b err=%b idx=%0d rx=%h, required all 0",
               state, SPI_MISO, tx_req, rx_valid, frame_done, frame_error, word_index, rx_word);
    end
    wait_clks(3);
    reset_n = 1'b1;
    wait_clks(10);
    checks++;
    if (state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL reset_idle: got state %0d, required 0", state);
    end
  endtask

  task automatic test_nominal();
    int rx0, tr0, d0;
    txseq = '{24'hABCDEF, 24'h111111, 24'h222222, 24'h333333, 24'h444444};
    mosi_w[0] = 24'h0655AA;
    for (int n = 1; n < 8; n++) mosi_w[n] = '0;
    load_tx_seq();
    for (int n = 0; n < FW; n++) rx_exp_q.push_back(mosi_w[n]);
    rx0 = rx_cnt; tr0 = txreq_cnt; d0 = done_cnt;
    begin_frame();
    spi_shift(FW * W);
    end_frame();
    for (int n = 0; n < FW; n++) begin
      checks++;
      if (miso_got[n] !== exp_miso(n)) begin
        errors++;
        $display("[TB] FAIL nominal_miso%0d: got %h, required %h", n, miso_got[n], exp_miso(n));
      end
    end
    checks++;
    if (rx_cnt - rx0 != FW || rx_exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL nominal_rx_count: got %0d, required %0d", rx_cnt - rx0, FW);
    end
    checks++;
    if (txreq_cnt - tr0 != (LB ? 1 : FW)) begin
      errors++;
      $display("[TB] FAIL nominal_tx_req: got %0d, required %0d", txreq_cnt - tr0, LB ? 1 : FW);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("[TB] FAIL nominal_frame_done: got %0d, required 1", done_cnt - d0);
    end
    checks++;
    if (frame_error !== 1'b0 || word_index !== 3'd5 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL nominal_status: got err=%b idx=%0d state=%0d, required err=0 idx=5 state=0",
               frame_error, word_index, state);
    end
  endtask

  task automatic test_short_frame();
    int rx0, d0;
    mosi_w[0] = 24'hFFFFFF;
    load_tx_seq();
    rx0 = rx_cnt; d0 = done_cnt;
    begin_frame();
    spi_shift(10);
    end_frame();
    checks++;
    if (miso_got[0][23:14] !== txseq[0][23:14]) begin
      errors++;
      $display("[TB] FAIL short_miso: got %h, required %h", miso_got[0][23:14], txseq[0][23:14]);
    end
    checks++;
    if (rx_cnt != rx0) begin
      errors++;
      $display("[TB] FAIL short_rx_valid: got %0d pulses, required 0", rx_cnt - rx0);
    end
    checks++;
    if (frame_error !== 1'b1 || done_cnt - d0 != 1 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL short_status: got err=%b done=%0d state=%0d, required err=1 done=1 state=0",
               frame_error, done_cnt - d0, state);
    end
  endtask

  task automatic test_overrun();
    int rx0, tr0;
    txseq = '{24'hABCDEF, 24'h111111, 24'h222222, 24'h333333, 24'h444444};
    for (int n = 0; n < 6; n++) mosi_w[n] = 24'h5A0000 | W'(n * 24'h000111 + 1);
    load_tx_seq();
    for (int n = 0; n < 6; n++) rx_exp_q.push_back(mosi_w[n]);
    rx0 = rx_cnt; tr0 = txreq_cnt;
    begin_frame();
    spi_shift(6 * W);
    checks++;
    if (word_index !== 3'd5 || frame_error !== 1'b1) begin
      errors++;
      $display("[TB] FAIL overrun_status: got idx=%0d err=%b, required idx=5 err=1", word_index, frame_error);
    end
    end_frame();
    for (int n = 0; n < 6; n++) begin
      checks++;
      if (miso_got[n] !== exp_miso(n)) begin
        errors++;
        $display("[TB] FAIL overrun_miso%0d: got %h, required %h", n, miso_got[n], exp_miso(n));
      end
    end
    checks++;
    if (rx_cnt - rx0 != 6 || txreq_cnt - tr0 != (LB ? 1 : FW)) begin
      errors++;
      $display("[TB] FAIL overrun_counts: got rx=%0d txreq=%0d, required rx=6 txreq=%0d",
               rx_cnt - rx0, txreq_cnt - tr0, LB ? 1 : FW);
    end
  endtask

  task automatic test_reset_mid_frame();
    int tr0;
    mosi_w[0] = 24'h0F0F0F;
    mosi_w[1] = 24'h00C3A5;
    mosi_w[2] = 24'hFFFFFF;
    load_tx_seq();
    rx_exp_q.push_back(mosi_w[0]);
    rx_exp_q.push_back(mosi_w[1]);
    begin_frame();
    spi_shift(2 * W + 12);
    checks++;
    if (word_index !== 3'd2) begin
      errors++;
      $display("[TB] FAIL midreset_pre_idx: got %0d, required 2", word_index);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({state, SPI_MISO, tx_req, rx_valid, frame_done, frame_error, word_index, rx_word} !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_values: got state=%0d miso=%b idx=%0d rx=%h err=%b, required all 0",
               state, SPI_MISO, word_index, rx_word, frame_error);
    end
    wait_clks(3);
    tr0 = txreq_cnt;
    reset_n = 1'b1;
    wait_clks(20);
    checks++;
    if (state !== 2'd0 || txreq_cnt != tr0) begin
      errors++;
      $display("[TB] FAIL midreset_cs_low_start: got state=%0d txreq=%0d, required state=0 txreq=0",
               state, txreq_cnt - tr0);
    end
    end_frame();
    test_nominal();
  endtask

  task automatic test_spurious_sclk();
    int rx0, bad;
    rx0 = rx_cnt;
    bad = 0;
    SPI_CS = 1'b1;
    for (int p = 0; p < 16; p++) begin
      SPI_SCLK = 1'b1;
      SPI_MOSI = p[0];
      wait_clks(6);
      if (SPI_MISO !== 1'b0) bad++;
      SPI_SCLK = 1'b0;
      wait_clks(6);
      if (SPI_MISO !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("[TB] FAIL spurious_miso: got %0d nonzero samples, required 0", bad);
    end
    checks++;
    if (rx_cnt != rx0 || state !== 2'd0) begin
      errors++;
      $display("[TB] FAIL spurious_rx: got rx=%0d state=%0d, required rx=0 state=0", rx_cnt - rx0, state);
    end
  endtask

`ifdef SPI_RESPONDER_LOOPBACK_EN
  task automatic test_loopback();
    int tr0;
    txseq = '{24'hABCDEF, 24'h111111, 24'h222222, 24'h333333, 24'h444444};
    mosi_w[0] = 24'h123456;
    mosi_w[1] = 24'h654321;
    load_tx_seq();
    rx_exp_q.push_back(mosi_w[0]);
    rx_exp_q.push_back(mosi_w[1]);
    tr0 = txreq_cnt;
    begin_frame();
    spi_shift(2 * W);
    end_frame();
    checks++;
    if (miso_got[0] !== 24'hABCDEF || miso_got[1] !== 24'h123456) begin
      errors++;
      $display("[TB] FAIL loopback_miso: got %h %h, required abcdef 123456", miso_got[0], miso_got[1]);
    end
    checks++;
    if (txreq_cnt - tr0 != 1 || frame_error !== 1'b0) begin
      errors++;
      $display("[TB] FAIL loopback_tx_req: got %0d err=%b, required 1 err=0", txreq_cnt - tr0, frame_error);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_short_frame();
    test_overrun();
    test_reset_mid_frame();
    test_spurious_sclk();
`ifdef SPI_RESPONDER_LOOPBACK_EN
    test_loopback();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
